// File: rtl/bg_pkg.sv
// Shared definitions for the background pipeline: image geometry, ROM address width,
// palette index type and the stored background image contents.
package bg_pkg;

  localparam int unsigned IMG_W  = 320;
  localparam int unsigned IMG_H  = 240;
  localparam int unsigned ADDR_W = 17;

  typedef logic [3:0] pal_idx_t;

  localparam pal_idx_t BLANK_INDEX = 4'hD;

  // Background image texel at a linear ROM address (nibble-fold pattern).
  function automatic pal_idx_t image_texel(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {3'b000, a[16]};
  endfunction

endpackage

// File: rtl/bg_idle_rom.sv
// Synchronous-read background image ROM; one 4-bpp palette index per address.
module bg_idle_rom
  import bg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output pal_idx_t          q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= image_texel(addr);
    end
  end

endmodule

// File: rtl/bg_index_fetch.sv
// Pixel-index fetch: beam coordinates -> scrolled, 2x-downscaled ROM address ->
// palette index with a matching visibility flag, two pix_en cycles of latency.
module bg_index_fetch
  import bg_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pix_en,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank_in,
  input  logic       frame_start,
  input  logic       scroll_en,
  input  logic [3:0] scroll_step,
  output pal_idx_t   index,
  output logic       blank_out,
  output logic [8:0] scroll_x
);

  logic [9:0]        sx_sum;
  logic [8:0]        sx;
  logic [ADDR_W-1:0] addr_c;
  logic              vis1_c;
  logic [9:0]        scr_sum;
  logic [8:0]        scr_next;

  logic [ADDR_W-1:0] addr1;
  logic              vis1;
  logic              vis2;
  pal_idx_t          rom_q;

  // Both sums stay below 2*IMG_W, so one conditional subtract wraps them.
  always_comb begin
    sx_sum = {1'b0, DrawX[9:1]} + {1'b0, scroll_x};
    if (sx_sum >= 10'(IMG_W)) begin
      sx_sum = sx_sum - 10'(IMG_W);
    end
    sx     = sx_sum[8:0];
    addr_c = ADDR_W'(DrawY[9:1]) * ADDR_W'(IMG_W) + ADDR_W'(sx);
    vis1_c = blank_in & (DrawX < 10'(2 * IMG_W)) & (DrawY < 10'(2 * IMG_H));

    scr_sum = {1'b0, scroll_x} + {6'b000000, scroll_step};
    if (scr_sum >= 10'(IMG_W)) begin
      scr_sum = scr_sum - 10'(IMG_W);
    end
    scr_next = scr_sum[8:0];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr1 <= '0;
      vis1  <= 1'b0;
      vis2  <= 1'b0;
    end else if (pix_en) begin
      addr1 <= addr_c;
      vis1  <= vis1_c;
      vis2  <= vis1;
    end
  end

  // Scroll updates regardless of pix_en; a pixel sampled on the same edge used the old value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scroll_x <= '0;
    end else if (frame_start && scroll_en) begin
      scroll_x <= scr_next;
    end
  end

  bg_idle_rom u_rom (
    .clk  (Clk),
    .rst  (Reset),
    .en   (pix_en),
    .addr (addr1),
    .q    (rom_q)
  );

  always_comb begin
    index     = vis2 ? rom_q : BLANK_INDEX;
    blank_out = vis2;
  end

endmodule

// File: tb/tb_bg_index_fetch.sv
// Scoreboard bench for bg_index_fetch: expected {blank_out,index} queued per pixel,
// popped when the pixel reaches the output two pix_en cycles later.
module tb_bg_index_fetch;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       pix_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank_in;
  logic       frame_start;
  logic       scroll_en;
  logic [3:0] scroll_step;
  logic [3:0] index;
  logic       blank_out;
  logic [8:0] scroll_x;

  bg_index_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_en      (pix_en),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank_in    (blank_in),
    .frame_start (frame_start),
    .scroll_en   (scroll_en),
    .scroll_step (scroll_step),
    .index       (index),
    .blank_out   (blank_out),
    .scroll_x    (scroll_x)
  );

  always #10 Clk = ~Clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] sb[$];
  logic [4:0] last_exp;
  int         sc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rom_model(input int a);
    int f;
    f = (a ^ (a >> 4) ^ (a >> 8) ^ (a >> 12) ^ (a >> 16)) & 15;
    return 4'(f);
  endfunction

  function automatic logic [4:0] model(input int x, input int y, input bit b);
    int sx, a;
    if (!b || x >= 640 || y >= 480) return 5'h0D;
    sx = ((x / 2) + sc) % 320;
    a  = (y / 2) * 320 + sx;
    return {1'b1, rom_model(a)};
  endfunction

  task automatic pix(input int x, input int y, input bit b,
                     input bit fs = 1'b0, input bit se = 1'b0, input int st = 0);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    blank_in    = b;
    pix_en      = 1'b1;
    frame_start = fs;
    scroll_en   = se;
    scroll_step = 4'(st);
    sb.push_back(model(x, y, b));
    @(posedge Clk);
    #1;
    if (fs && se) sc = (sc + st) % 320;
    pix_en      = 1'b0;
    frame_start = 1'b0;
    if (sb.size() == 2) begin
      last_exp = sb.pop_front();
      check("pix", {27'd0, blank_out, index}, {27'd0, last_exp});
    end
    if (fs) check("scroll_sim", {23'd0, scroll_x}, sc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pix_en = 1'b0;
      DrawX  = 10'($urandom_range(0, 799));
      DrawY  = 10'($urandom_range(0, 524));
      @(posedge Clk);
      #1;
      check("hold", {27'd0, blank_out, index}, {27'd0, last_exp});
    end
  endtask

  task automatic frame(input bit se, input int st);
    frame_start = 1'b1;
    scroll_en   = se;
    scroll_step = 4'(st);
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    if (se) sc = (sc + st) % 320;
    check("scroll", {23'd0, scroll_x}, sc);
  endtask

  task automatic do_reset();
    #3;
    Reset = 1'b1;
    #1;
    check("rst_index", {28'd0, index}, 32'hD);
    check("rst_blank", {31'd0, blank_out}, 0);
    check("rst_scroll", {23'd0, scroll_x}, 0);
    sb.delete();
    sc       = 0;
    last_exp = 5'h0D;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; pix_en = 1'b0; DrawX = '0; DrawY = '0; blank_in = 1'b0;
    frame_start = 1'b0; scroll_en = 1'b0; scroll_step = '0;
    sc = 0; last_exp = 5'h0D;
    #5;
    check("por_index", {28'd0, index}, 32'hD);
    check("por_blank", {31'd0, blank_out}, 0);
    check("por_scroll", {23'd0, scroll_x}, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // origin pixel and neighbours at zero scroll
    pix(0, 0, 1'b1);
    pix(2, 0, 1'b1);
    pix(5, 3, 1'b1);

    // scrolled wrap at the right edge, then the invisible cases
    frame(1'b1, 5);
    pix(638, 2, 1'b1);
    pix(700, 10, 1'b1);
    check("wrap_addr324", {27'd0, blank_out, index}, {27'd0, 1'b1, rom_model(324)});
    pix(100, 100, 1'b0);
    pix(10, 500, 1'b1);
    pix(639, 479, 1'b1);

    // stall with a pixel still in flight, then resume in order
    idle(5);
    pix(20, 20, 1'b1);
    pix(30, 30, 1'b1);

    // scroll accumulation to 315, hold with scroll_en=0, wrap to 5
    for (int i = 0; i < 31; i++) frame(1'b1, 10);
    check("scroll_315", {23'd0, scroll_x}, 315);
    frame(1'b0, 10);
    frame(1'b1, 10);
    check("scroll_wrap5", {23'd0, scroll_x}, 5);

    // frame_start coincident with pix_en: that pixel sees the old scroll
    pix(50, 50, 1'b1, 1'b1, 1'b1, 7);
    pix(52, 50, 1'b1);
    pix(54, 50, 1'b1);

    // mid-line reset flushes the pipeline
    pix(60, 60, 1'b1);
    pix(62, 60, 1'b1);
    do_reset();
    pix(64, 60, 1'b1);
    check("rst_flush", {27'd0, blank_out, index}, 32'h0D);
    pix(66, 60, 1'b1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0)
        pix($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)),
            1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      else
        pix($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 3) != 0));
    end
    pix(0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
